// File: rtl/pool_feeder.sv
// Command-driven stream master for the average-pooling engine: fetches the input
// map from a source RAM into the engine and drains results into a destination RAM.
module pool_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int TYPE1_LEN  = 325,
    parameter int TYPE2_LEN  = 4000,
    parameter int TYPE1_OLEN = 1,
    parameter int TYPE2_OLEN = 325
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  CMD_VLD,
    output logic                  CMD_RDY,
    input  logic [1:0]            CMD_PLTY,
    input  logic [ADDR_WIDTH-1:0] CMD_SRC_BASE,
    input  logic [ADDR_WIDTH-1:0] CMD_DST_BASE,
    output logic                  SRC_RE,
    output logic [ADDR_WIDTH-1:0] SRC_ADDR,
    input  logic [DATA_WIDTH-1:0] SRC_DATA,
    output logic                  PL_START,
    output logic [1:0]            PL_PLTY,
    output logic [DATA_WIDTH-1:0] PL_DIN,
    output logic                  PL_DIN_VLD,
    input  logic                  PL_DIN_RDY,
    input  logic [DATA_WIDTH-1:0] PL_DOUT,
    input  logic                  PL_DOUT_VLD,
    output logic                  PL_DOUT_RDY,
    input  logic                  PL_DOUT_OVFL,
    output logic                  DST_WE,
    output logic [ADDR_WIDTH-1:0] DST_ADDR,
    output logic [DATA_WIDTH-1:0] DST_DATA,
    output logic                  DONE,
    output logic                  ERR,
    output logic [ADDR_WIDTH-1:0] OVFL_CNT
);
    localparam int CNT_W = $clog2(TYPE2_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STRT  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_plty;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_src_base;
    logic [ADDR_WIDTH-1:0] r_dst_base;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_xfer_cnt;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_ovfl_cnt;
    logic [DATA_WIDTH-1:0] r_fifo [4];
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic [2:0]            r_occ;
    logic                  r_inflight;

    logic                  w_cmd_acc;
    logic                  w_cmd_bad;
    logic [CNT_W-1:0]      w_len;
    logic [CNT_W-1:0]      w_olen;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_dout_rdy;
    logic                  w_dout_xfer;
    logic [CNT_W-1:0]      w_wr_cnt_nxt;
    logic                  w_last_din;

    assign w_cmd_acc    = (r_state == S_IDLE) && CMD_VLD && EN;
    assign w_cmd_bad    = (CMD_PLTY == 2'b00) || (CMD_PLTY == 2'b11);
    assign w_len        = (r_plty == 2'b01) ? CNT_W'(TYPE1_LEN)  : CNT_W'(TYPE2_LEN);
    assign w_olen       = (r_plty == 2'b01) ? CNT_W'(TYPE1_OLEN) : CNT_W'(TYPE2_OLEN);
    assign w_push       = r_inflight && EN;
    assign w_pop        = (r_state == S_FEED) && (r_occ != 3'd0) && PL_DIN_RDY && EN;
    // Reserve a slot for every read still in flight so the FIFO can never overflow.
    assign w_issue      = EN && (r_state == S_FEED) && (r_rd_cnt < w_len) &&
                          (({1'b0, r_occ} + {3'b000, r_inflight} - {3'b000, w_pop}) < 4'd4);
    assign w_dout_rdy   = ((r_state == S_FEED) || (r_state == S_DRAIN)) && (r_wr_cnt < w_olen);
    assign w_dout_xfer  = PL_DOUT_VLD && w_dout_rdy && EN;
    assign w_wr_cnt_nxt = r_wr_cnt + (w_dout_xfer ? CNT_W'(1) : CNT_W'(0));
    assign w_last_din   = w_pop && (r_xfer_cnt == (w_len - CNT_W'(1)));

    // Next-state decode for the command sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    w_state_nxt = w_cmd_bad ? S_FIN : S_STRT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STRT: begin
                if (EN) begin
                    w_state_nxt = S_FEED;
                end else begin
                    w_state_nxt = S_STRT;
                end
            end
            S_FEED: begin
                if (w_last_din) begin
                    w_state_nxt = (w_wr_cnt_nxt == w_olen) ? S_FIN : S_DRAIN;
                end else begin
                    w_state_nxt = S_FEED;
                end
            end
            S_DRAIN: begin
                if (EN && (w_wr_cnt_nxt == w_olen)) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_FIN: begin
                if (EN) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, command latch, counters and FIFO bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_plty     <= 2'b00;
            r_err      <= 1'b0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_rd_cnt   <= '0;
            r_xfer_cnt <= '0;
            r_wr_cnt   <= '0;
            r_ovfl_cnt <= '0;
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_occ      <= 3'd0;
            r_inflight <= 1'b0;
        end else if (EN) begin
            r_state <= w_state_nxt;
            if (w_cmd_acc) begin
                r_plty     <= CMD_PLTY;
                r_err      <= w_cmd_bad;
                r_src_base <= CMD_SRC_BASE;
                r_dst_base <= CMD_DST_BASE;
                r_rd_cnt   <= '0;
                r_xfer_cnt <= '0;
                r_wr_cnt   <= '0;
                r_ovfl_cnt <= '0;
            end else begin
                r_rd_cnt   <= r_rd_cnt + (w_issue ? CNT_W'(1) : CNT_W'(0));
                r_xfer_cnt <= r_xfer_cnt + (w_pop ? CNT_W'(1) : CNT_W'(0));
                r_wr_cnt   <= w_wr_cnt_nxt;
                r_ovfl_cnt <= r_ovfl_cnt + ((w_dout_xfer && PL_DOUT_OVFL) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0));
            end
            r_wptr     <= r_wptr + (w_push ? 2'd1 : 2'd0);
            r_rptr     <= r_rptr + (w_pop ? 2'd1 : 2'd0);
            r_occ      <= r_occ + {2'b00, w_push} - {2'b00, w_pop};
            r_inflight <= w_issue;
        end
    end

    // Prefetch FIFO storage; contents are meaningless whenever r_occ is zero.
    always_ff @(posedge CLK) begin
        if (EN && w_push) begin
            r_fifo[r_wptr] <= SRC_DATA;
        end
    end

    assign CMD_RDY     = (r_state == S_IDLE) && !RESET;
    assign SRC_RE      = w_issue;
    assign SRC_ADDR    = r_src_base + ADDR_WIDTH'(r_rd_cnt);
    assign PL_START    = (r_state == S_STRT);
    assign PL_PLTY     = r_plty;
    assign PL_DIN_VLD  = (r_occ != 3'd0);
    assign PL_DIN      = PL_DIN_VLD ? r_fifo[r_rptr] : '0;
    assign PL_DOUT_RDY = w_dout_rdy;
    assign DST_WE      = w_dout_xfer;
    assign DST_ADDR    = r_dst_base + ADDR_WIDTH'(r_wr_cnt);
    assign DST_DATA    = w_dout_xfer ? PL_DOUT : '0;
    assign DONE        = (r_state == S_FIN);
    assign ERR         = (r_state == S_FIN) && r_err;
    assign OVFL_CNT    = r_ovfl_cnt;
endmodule

// File: tb/tb_pool_feeder.sv
// Bench for pool_feeder: source RAM and pooling-engine models with scoreboards for
// the sample stream and the destination writes, driven from a table of commands.
module tb_pool_feeder;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RESET, EN, CMD_VLD, CMD_RDY;
    logic [1:0]    CMD_PLTY, PL_PLTY;
    logic [AW-1:0] CMD_SRC_BASE, CMD_DST_BASE, SRC_ADDR, DST_ADDR, OVFL_CNT;
    logic          SRC_RE, PL_START, PL_DIN_VLD, PL_DIN_RDY, PL_DOUT_VLD, PL_DOUT_RDY;
    logic          PL_DOUT_OVFL, DST_WE, DONE, ERR;
    logic [DW-1:0] SRC_DATA, PL_DIN, PL_DOUT, DST_DATA;

    pool_feeder dut (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_PLTY(CMD_PLTY),
        .CMD_SRC_BASE(CMD_SRC_BASE), .CMD_DST_BASE(CMD_DST_BASE),
        .SRC_RE(SRC_RE), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
        .PL_START(PL_START), .PL_PLTY(PL_PLTY), .PL_DIN(PL_DIN),
        .PL_DIN_VLD(PL_DIN_VLD), .PL_DIN_RDY(PL_DIN_RDY),
        .PL_DOUT(PL_DOUT), .PL_DOUT_VLD(PL_DOUT_VLD), .PL_DOUT_RDY(PL_DOUT_RDY),
        .PL_DOUT_OVFL(PL_DOUT_OVFL), .DST_WE(DST_WE), .DST_ADDR(DST_ADDR),
        .DST_DATA(DST_DATA), .DONE(DONE), .ERR(ERR), .OVFL_CNT(OVFL_CNT)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] src_mem [4096];
    always @(posedge CLK) if (SRC_RE) SRC_DATA <= src_mem[SRC_ADDR];

    typedef struct {
        logic [1:0]  plty;
        logic [11:0] src;
        logic [11:0] dst;
        bit          rdy_rand;
        bit          gap_rand;
        bit          ovfl_mode;
        int          salt;
        bit          exp_err;
        int          exp_ovfl;
        int          exp_len;
        int          exp_olen;
    } vec_t;
    vec_t tv [6];

    int errors = 0, checks = 0;
    logic [DW-1:0]    exp_din [$];
    logic [AW+DW-1:0] exp_dst [$];

    // command context written by the main sequence
    int            cmd_id = 0;
    logic [AW-1:0] cur_src = '0, cur_dst = '0;
    logic [1:0]    cur_plty = 2'b00;
    int            cur_len = 0, cur_olen = 0;
    bit            rdy_rand = 1'b0, gap_rand = 1'b0, ovfl_mode = 1'b0;

    // monitor-owned statistics
    int cyc = 0, mon_id = 0;
    int t_acc, start_cnt, start_cyc, re_cnt, first_re, first_vld, din_cnt, last_xfer;
    int dst_cnt, last_wr, done_seen, done_cyc, done_err, done_ovfl, ovfl_t1;
    int dout_last_cyc = -10;
    bit prev_hold = 1'b0, din_x;
    logic [DW-1:0] prev_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] res_val(input logic [1:0] plty, input int idx);
        return (plty == 2'b01) ? 16'h0ABC : DW'(32'h2000 + idx);
    endfunction

    // Monitor: samples just before each rising edge, after inputs have settled.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(posedge CLK);
            cyc++;
            #8;
            if (cmd_id != mon_id) begin
                mon_id = cmd_id; t_acc = -1; start_cnt = 0; start_cyc = -1; re_cnt = 0;
                first_re = -1; first_vld = -1; din_cnt = 0; last_xfer = -1; dst_cnt = 0;
                last_wr = -1; done_seen = 0; done_cyc = -1; done_err = 0; done_ovfl = 0;
                ovfl_t1 = -1; prev_hold = 1'b0;
            end
            if (RESET) begin
                prev_hold = 1'b0;
            end else begin
                if (CMD_VLD && CMD_RDY && EN) t_acc = cyc;
                if (t_acc >= 0 && cyc == t_acc + 1) ovfl_t1 = int'(OVFL_CNT);
                if (PL_START) begin
                    start_cnt++;
                    if (start_cyc < 0) start_cyc = cyc;
                end
                if (SRC_RE) begin
                    chk("src_addr", 32'(SRC_ADDR), 32'(AW'(cur_src + AW'(re_cnt))));
                    if (first_re < 0) first_re = cyc;
                    re_cnt++;
                end
                if (PL_DIN_VLD && first_vld < 0) first_vld = cyc;
                if (prev_hold) begin
                    chk("din_stable_vld", 32'(PL_DIN_VLD), 32'd1);
                    chk("din_stable_data", 32'(PL_DIN), 32'(prev_din));
                end
                din_x = PL_DIN_VLD && PL_DIN_RDY && EN;
                if (din_x) begin
                    if (exp_din.size() == 0) chk("din_extra", 32'd1, 32'd0);
                    else chk("din_data", 32'(PL_DIN), 32'(exp_din.pop_front()));
                    din_cnt++;
                    last_xfer = cyc;
                end
                prev_hold = PL_DIN_VLD && !din_x;
                prev_din  = PL_DIN;
                if (PL_DOUT_VLD && EN) chk("dst_we_vs_rdy", 32'(DST_WE), 32'(PL_DOUT_RDY));
                if (DST_WE) begin
                    if (exp_dst.size() == 0) chk("dst_extra", 32'd1, 32'd0);
                    else begin
                        e = exp_dst.pop_front();
                        chk("dst_addr", 32'(DST_ADDR), 32'(e[AW+DW-1:DW]));
                        chk("dst_data", 32'(DST_DATA), 32'(e[DW-1:0]));
                    end
                    dst_cnt++;
                    last_wr = cyc;
                    dout_last_cyc = cyc;
                end
                if (DONE) begin
                    done_seen++; done_cyc = cyc; done_err = int'(ERR); done_ovfl = int'(OVFL_CNT);
                end
            end
        end
    end

    // Pooling-engine model: accepts samples, then emits the result words.
    initial begin
        int res_idx = 0, eng_id = 0;
        PL_DIN_RDY = 1'b0; PL_DOUT_VLD = 1'b0; PL_DOUT = '0; PL_DOUT_OVFL = 1'b0;
        forever begin
            @(negedge CLK);
            if (eng_id != cmd_id) begin
                eng_id = cmd_id; res_idx = 0; PL_DOUT_VLD = 1'b0; PL_DOUT_OVFL = 1'b0;
                exp_dst.delete();
            end
            PL_DIN_RDY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (PL_DOUT_VLD && dout_last_cyc == cyc - 1) begin
                PL_DOUT_VLD = 1'b0;
                res_idx++;
            end
            if (!PL_DOUT_VLD && mon_id == cmd_id && cur_len > 0 && din_cnt == cur_len &&
                res_idx < cur_olen && (!gap_rand || $urandom_range(0, 1) == 1)) begin
                PL_DOUT      = res_val(cur_plty, res_idx);
                PL_DOUT_OVFL = ovfl_mode && (res_idx == 0 || res_idx == 100 || res_idx == 324);
                PL_DOUT_VLD  = 1'b1;
                exp_dst.push_back({AW'(cur_dst + AW'(res_idx)), PL_DOUT});
            end
        end
    end

    task automatic start_cmd(input int k);
        cur_plty = tv[k].plty; cur_src = tv[k].src; cur_dst = tv[k].dst;
        cur_len = tv[k].exp_len; cur_olen = tv[k].exp_olen;
        rdy_rand = tv[k].rdy_rand; gap_rand = tv[k].gap_rand; ovfl_mode = tv[k].ovfl_mode;
        exp_din.delete();
        for (int i = 0; i < cur_len; i++) begin
            src_mem[AW'(cur_src + AW'(i))] = DW'(i + tv[k].salt);
            exp_din.push_back(DW'(i + tv[k].salt));
        end
        cmd_id++;
        CMD_PLTY = tv[k].plty; CMD_SRC_BASE = tv[k].src; CMD_DST_BASE = tv[k].dst;
        CMD_VLD = 1'b1;
        @(negedge CLK);
        CMD_VLD = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge CLK); #9;
            if (done_seen > 0) break;
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        @(posedge CLK); #9;
        chk("cmd_rdy_after_done", 32'(CMD_RDY), 32'd1);
        chk("done_one_cycle", 32'(DONE), 32'd0);
        @(negedge CLK);
    endtask

    task automatic verify(input int k, input bit burst);
        chk("accepted", 32'(t_acc >= 0), 32'd1);
        chk("err", 32'(done_err), 32'(tv[k].exp_err));
        chk("ovfl_cnt", 32'(done_ovfl), 32'(tv[k].exp_ovfl));
        chk("ovfl_cleared", 32'(ovfl_t1), 32'd0);
        chk("reads", 32'(re_cnt), 32'(tv[k].exp_len));
        chk("xfers", 32'(din_cnt), 32'(tv[k].exp_len));
        chk("writes", 32'(dst_cnt), 32'(tv[k].exp_olen));
        chk("starts", 32'(start_cnt), tv[k].exp_err ? 32'd0 : 32'd1);
        chk("din_q_empty", 32'(exp_din.size()), 32'd0);
        chk("dst_q_empty", 32'(exp_dst.size()), 32'd0);
        if (tv[k].exp_err) begin
            chk("err_done_lat", 32'(done_cyc - t_acc), 32'd1);
        end else begin
            chk("start_lat", 32'(start_cyc - t_acc), 32'd1);
            chk("re_lat", 32'(first_re - t_acc), 32'd2);
            chk("vld_lat", 32'(first_vld - t_acc), 32'd4);
            chk("done_lat", 32'(done_cyc - last_wr), 32'd1);
            if (!tv[k].rdy_rand && !burst)
                chk("no_bubbles", 32'(last_xfer - first_vld), 32'(tv[k].exp_len - 1));
        end
    endtask

    initial begin
        int b, r0;
        tv[0] = '{2'b01, 12'h100, 12'h200, 1'b0, 1'b0, 1'b0, 0,      1'b0, 0, 325,  1};
        tv[1] = '{2'b10, 12'h000, 12'h400, 1'b1, 1'b1, 1'b0, 16'h300, 1'b0, 0, 4000, 325};
        tv[2] = '{2'b11, 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 0,      1'b1, 0, 0,    0};
        tv[3] = '{2'b10, 12'h800, 12'h010, 1'b0, 1'b0, 1'b1, 16'h77, 1'b0, 3, 4000, 325};
        tv[4] = '{2'b01, 12'hFF0, 12'hFFF, 1'b0, 1'b0, 1'b0, 16'h40, 1'b0, 0, 325,  1};
        tv[5] = '{2'b00, 12'h010, 12'h020, 1'b0, 1'b0, 1'b0, 0,      1'b1, 0, 0,    0};

        RESET = 1'b1; EN = 1'b1; CMD_VLD = 1'b0; CMD_PLTY = 2'b00;
        CMD_SRC_BASE = '0; CMD_DST_BASE = '0;
        repeat (3) @(negedge CLK);
        chk("reset_cmd_rdy", 32'(CMD_RDY), 32'd0);
        chk("reset_outs", 32'({SRC_RE, SRC_ADDR, PL_START, PL_PLTY, PL_DIN_VLD, PL_DOUT_RDY,
                                DST_WE, DST_ADDR, DONE, ERR, OVFL_CNT} != '0), 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #9;
        chk("cmd_rdy_after_reset", 32'(CMD_RDY), 32'd1);
        @(negedge CLK);

        for (int k = 0; k < 6; k++) begin
            start_cmd(k);
            wait_done(20000);
            verify(k, 1'b0);
        end

        // abort with RESET after transfer 100, then restart cleanly
        start_cmd(0);
        for (int i = 0; i < 2000 && din_cnt < 101; i++) @(negedge CLK);
        chk("reached_xfer_100", 32'(din_cnt >= 101), 32'd1);
        RESET = 1'b1;
        cur_len = 0; exp_din.delete(); cmd_id++;
        @(posedge CLK); #1;
        chk("abort_outs", 32'({CMD_RDY, SRC_RE, SRC_ADDR, PL_START, PL_PLTY, PL_DIN, PL_DIN_VLD,
                               PL_DOUT_RDY, DST_WE, DST_ADDR, DST_DATA, DONE, ERR, OVFL_CNT} != '0),
            32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        chk("no_done_after_abort", 32'(done_seen), 32'd0);
        start_cmd(0);
        wait_done(20000);
        verify(0, 1'b0);

        // EN=0 burst in the middle of FEED
        start_cmd(0);
        for (int i = 0; i < 2000 && din_cnt < 50; i++) @(negedge CLK);
        EN = 1'b0;
        @(negedge CLK);
        b = din_cnt; r0 = re_cnt;
        repeat (10) @(negedge CLK);
        chk("en_hold_xfers", 32'(din_cnt), 32'(b));
        chk("en_hold_reads", 32'(re_cnt), 32'(r0));
        EN = 1'b1;
        wait_done(20000);
        verify(0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
